// File: rtl/handshake_const_compare_if.sv
// Elastic handshake bundle for handshake_const_compare.
//   ins/ins_valid/ins_ready    : input data channel (producer -> unit)
//   outs/outs_valid/outs_ready : 1-bit result channel (unit -> consumer)
// master = the side that feeds ins and consumes outs; slave = the unit.
interface handshake_const_compare_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic                  outs;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid
    );
endinterface

// File: rtl/handshake_const_compare.sv
// Elastic equality test against a compile-time constant.
// Each accepted input token produces one 1-bit result token (1 = equal),
// buffered in a 2-entry FIFO so ins_ready never depends on outs_ready.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   bus         : slave side of handshake_const_compare_if (ins*, outs*)
//   match_count : saturating count of accepted tokens that matched
module handshake_const_compare #(
    parameter int          DATA_WIDTH  = 32,
    parameter int unsigned CONST_VALUE = 28,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    handshake_const_compare_if.slave bus,
    output logic [CNT_WIDTH-1:0] match_count
);
    // Zero-extend or truncate the constant to the data width.
    localparam logic [DATA_WIDTH-1:0] CONST_CMP = DATA_WIDTH'(CONST_VALUE);

    logic [1:0]           mem_q, mem_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] match_cnt_q, match_cnt_d;

    logic push;
    logic pop;
    logic is_match;

    // Readiness comes only from the registered occupancy (and reset), which
    // breaks the combinational path from outs_ready back to ins_ready.
    assign bus.ins_ready  = rst & (cnt_q != 2'd2);
    assign bus.outs_valid = (cnt_q != 2'd0);
    // Masked so an empty FIFO always presents 0 rather than a stale entry.
    assign bus.outs       = bus.outs_valid & mem_q[rd_ptr_q];
    assign match_count    = match_cnt_q;

    assign push     = bus.ins_valid & bus.ins_ready;
    assign pop      = bus.outs_valid & bus.outs_ready;
    assign is_match = (bus.ins == CONST_CMP);

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        match_cnt_d = match_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = is_match;
            wr_ptr_d        = ~wr_ptr_q;
            if (is_match && (match_cnt_q != {CNT_WIDTH{1'b1}})) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            match_cnt_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end
endmodule

// File: doc/handshake_const_compare.md
Name: handshake_const_compare

Overview:
- Elastic dataflow unit that consumes tokens on a DATA_WIDTH data channel and tests each one for equality with a compile-time constant.
- Emits one 1-bit result token per consumed input on an output channel, which a downstream branch or merge typically consumes.
- A 2-entry FIFO decouples the input and output channels, so there is no combinational path from outs_ready to ins_ready.
- Keeps a saturating count of matching tokens for debug and profiling.

Parameters:
- DATA_WIDTH, 32: width of the input data channel.
- CONST_VALUE, 28 (6'b011100): value compared against. Zero-extended or truncated to DATA_WIDTH.
- CNT_WIDTH, 16: width of the match counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ins  input  DATA_WIDTH  input token data.
- ins_valid  input  1  input token present.
- ins_ready  output  1  unit accepts the input token this cycle.
- outs  output  1  result token: 1 = ins equalled CONST_VALUE.
- outs_valid  output  1  result token present.
- outs_ready  input  1  consumer accepts the result token.
- match_count  output  CNT_WIDTH  number of accepted matching tokens, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO count=0, read pointer=0, write pointer=0.
  - match_count=0.
  - Outputs while in reset: outs_valid=0, ins_ready=0, outs=0.
  - Deassertion takes effect at the next clk edge; ins_ready=1 in the first cycle after release.
- Storage: 2-entry FIFO of 1-bit results, 1-bit read/write pointers, 2-bit count.
- ins_ready = rst & (count != 2). It is purely registered and does not depend on outs_ready.
- Push when ins_valid & ins_ready:
  - Write (ins == CONST_VALUE[DATA_WIDTH-1:0]) at the write pointer.
  - Advance the write pointer, wrapping 1 to 0.
- Pop when outs_valid & outs_ready: advance the read pointer, wrapping 1 to 0.
- outs_valid = (count != 0). outs = entry at the read pointer; it is 0 when the FIFO is empty.
- Count update on each edge:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - Simultaneous push and pop is legal at count=1. It cannot occur at count=2, because ins_ready=0 there.
- Latency: a token accepted in cycle N presents outs_valid in cycle N+1. Empty FIFO never bypasses combinationally.
- Ordering: strict FIFO; every accepted input produces exactly one output token.
- Throughput: 1 token/cycle sustained when outs_ready=1 continuously.
- match_count:
  - Increments on push when the result is 1.
  - Holds at 2^CNT_WIDTH-1; never wraps.
- Stability: while outs_valid=1 and outs_ready=0, outs and outs_valid hold their values.
- Reset mid-operation: all buffered tokens are discarded and match_count is cleared asynchronously.

Test Plan:
1. Reset release, then ins=28 with ins_valid=1 for one cycle, outs_ready=1 -> outs_valid=1, outs=1 the next cycle; then outs_valid=0; match_count=1.
2. Stream ins=28,5,28,0 back-to-back with outs_ready=1 -> outs sequence 1,0,1,0, each 1 cycle after acceptance; ins_ready stays 1; match_count=2.
3. outs_ready=0, offer ins=28,3,28 -> first two are accepted; ins_ready=0 from the third cycle while the third token is held; outs stays 1. Raise outs_ready -> outputs 1,0,1 in order; third token is accepted once count<2.
4. count=1 with simultaneous push (ins=7) and pop -> count stays 1; next outs=0; pointers wrap correctly over 8 such cycles.
5. CNT_WIDTH=2, send 5 matching tokens -> match_count reads 1,2,3,3,3.
6. Two tokens buffered, assert rst=0 asynchronously mid-cycle -> outs_valid, ins_ready and match_count go to 0 immediately; after release, no stale tokens are emitted.
